// File: rtl/radiometer_integrator.sv
// Dicke-switched multi-channel integrator: sorts samples by switch phase, blanks settling samples,
// integrates over INT_PERIODS switch periods and streams per-channel (signal - reference) sums.
module radiometer_integrator #(
   parameter int NUM_CH      = 2,
   parameter int SAMPLE_W    = 12,
   parameter int ACC_W       = 32,
   parameter int INT_PERIODS = 256,
   parameter int BLANK_CYC   = 16,
   localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       switch_pwm,
   input  logic                       sample_valid,
   input  logic [NUM_CH*SAMPLE_W-1:0] sample_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [CH_W-1:0]            out_chan,
   output logic [ACC_W:0]             out_data,
   output logic                       out_last,
   output logic                       out_sat,
   output logic                       overrun,
   output logic                       integ_active
);

   localparam int PC_W  = (INT_PERIODS > 1) ? $clog2(INT_PERIODS) : 1;
   localparam int BC_W  = (BLANK_CYC > 0) ? $clog2(BLANK_CYC + 1) : 1;
   localparam int SUM_W = ACC_W + 1;

   typedef enum logic [1:0] {ST_SYNC, ST_BLANK, ST_ACCUM} state_t;

   // With no blanking an edge leads straight back into accumulation.
   localparam state_t ST_AFTER_EDGE = (BLANK_CYC == 0) ? ST_ACCUM : ST_BLANK;

   state_t            state_q, state_d;
   logic              pwm_s1, ph, ph_d;
   logic              edge_cyc, rise_cyc;
   logic [BC_W-1:0]   blank_cnt;
   logic [PC_W-1:0]   period_cnt;
   logic              period_wrap;

   logic              blank_load, blank_dec, per_clr, per_inc, acc_clr, acc_en, snapshot;

   logic [ACC_W-1:0]  sig_acc  [NUM_CH];
   logic [ACC_W-1:0]  ref_acc  [NUM_CH];
   logic              acc_sat  [NUM_CH];
   logic [SUM_W-1:0]  acc_sum  [NUM_CH];
   logic [ACC_W-1:0]  acc_next [NUM_CH];
   logic              acc_ovf  [NUM_CH];

   logic [ACC_W:0]    res_data [NUM_CH];
   logic              res_sat  [NUM_CH];
   logic              valid_q, overrun_q;
   logic [CH_W-1:0]   beat_q;
   logic              last_beat, xfer, buf_free;

   assign edge_cyc    = ph != ph_d;
   assign rise_cyc    = ph & ~ph_d;
   assign period_wrap = period_cnt == PC_W'(INT_PERIODS - 1);

   always_comb begin
      state_d    = state_q;
      blank_load = 1'b0;
      blank_dec  = 1'b0;
      per_clr    = 1'b0;
      per_inc    = 1'b0;
      acc_clr    = 1'b0;
      acc_en     = 1'b0;
      snapshot   = 1'b0;
      case (state_q)
         ST_SYNC: begin
            if (rise_cyc) begin
               state_d    = ST_AFTER_EDGE;
               blank_load = 1'b1;
               per_clr    = 1'b1;
               acc_clr    = 1'b1;
            end
         end
         ST_BLANK, ST_ACCUM: begin
            // The sample that coincides with an edge is always dropped.
            if (edge_cyc) begin
               state_d    = ST_AFTER_EDGE;
               blank_load = 1'b1;
               if (rise_cyc) begin
                  per_inc  = 1'b1;
                  snapshot = period_wrap;
                  acc_clr  = period_wrap;
               end
            end else if (sample_valid) begin
               if (state_q == ST_BLANK) begin
                  blank_dec = 1'b1;
                  if (blank_cnt == BC_W'(1)) state_d = ST_ACCUM;
               end else begin
                  acc_en = 1'b1;
               end
            end
         end
         default: state_d = ST_SYNC;
      endcase
   end

   always_comb begin
      for (int k = 0; k < NUM_CH; k++) begin
         acc_sum[k]  = (ph ? {1'b0, sig_acc[k]} : {1'b0, ref_acc[k]})
                       + SUM_W'(sample_data[k*SAMPLE_W +: SAMPLE_W]);
         acc_ovf[k]  = acc_sum[k][ACC_W];
         acc_next[k] = acc_ovf[k] ? '1 : acc_sum[k][ACC_W-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         pwm_s1     <= 1'b0;
         ph         <= 1'b0;
         ph_d       <= 1'b0;
         state_q    <= ST_SYNC;
         blank_cnt  <= '0;
         period_cnt <= '0;
      end else begin
         pwm_s1  <= switch_pwm;
         ph      <= pwm_s1;
         ph_d    <= ph;
         state_q <= state_d;
         if (blank_load)     blank_cnt <= BC_W'(BLANK_CYC);
         else if (blank_dec) blank_cnt <= blank_cnt - BC_W'(1);
         if (per_clr)        period_cnt <= '0;
         else if (per_inc)   period_cnt <= period_wrap ? '0 : period_cnt + PC_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      for (int k = 0; k < NUM_CH; k++) begin
         if (!reset || acc_clr) begin
            sig_acc[k] <= '0;
            ref_acc[k] <= '0;
            acc_sat[k] <= 1'b0;
         end else if (acc_en) begin
            if (ph) sig_acc[k] <= acc_next[k];
            else    ref_acc[k] <= acc_next[k];
            if (acc_ovf[k]) acc_sat[k] <= 1'b1;
         end
      end
   end

   // Result stream: a beat moves when out_valid && out_ready; while stalled every out_* holds.
   assign last_beat = beat_q == CH_W'(NUM_CH - 1);
   assign xfer      = valid_q && out_ready;
   assign buf_free  = !valid_q || (xfer && last_beat);

   always_ff @(posedge clk) begin
      if (!reset) begin
         valid_q   <= 1'b0;
         beat_q    <= '0;
         overrun_q <= 1'b0;
         for (int k = 0; k < NUM_CH; k++) begin
            res_data[k] <= '0;
            res_sat[k]  <= 1'b0;
         end
      end else begin
         if (xfer) begin
            if (last_beat) begin
               valid_q <= 1'b0;
               beat_q  <= '0;
            end else begin
               beat_q  <= beat_q + CH_W'(1);
            end
         end
         if (snapshot) begin
            if (buf_free) begin
               valid_q <= 1'b1;
               beat_q  <= '0;
               for (int k = 0; k < NUM_CH; k++) begin
                  res_data[k] <= {1'b0, sig_acc[k]} - {1'b0, ref_acc[k]};
                  res_sat[k]  <= acc_sat[k];
               end
            end else begin
               overrun_q <= 1'b1;
            end
         end
      end
   end

   assign out_valid    = valid_q;
   assign out_chan     = beat_q;
   assign out_data     = res_data[beat_q];
   assign out_sat      = res_sat[beat_q];
   assign out_last     = valid_q && last_beat;
   assign overrun      = overrun_q;
   assign integ_active = state_q != ST_SYNC;

endmodule
